// File: rtl/calc_key_sequencer_if.sv
// Keypad-side and CU/IU-side signal bundle of the calculator key sequencer.
interface calc_key_sequencer_if #(
  parameter int unsigned OPW = 14
);

  logic           key_valid;
  logic [3:0]     key_code;
  logic           trig;
  logic [2:0]     value;
  logic           ClearEntry;
  logic [OPW-1:0] operand;
  logic [2:0]     digit_count;
  logic [1:0]     phase;
  logic           err;
  logic           busy;

  // Keypad encoder / environment side: drives keys, observes the sequencer.
  modport master (
    output key_valid, key_code,
    input  trig, value, ClearEntry, operand, digit_count, phase, err, busy
  );

  // Sequencer side: consumes keys, drives the CU/IU controls.
  modport slave (
    input  key_valid, key_code,
    output trig, value, ClearEntry, operand, digit_count, phase, err, busy
  );

endinterface

// File: rtl/calc_key_sequencer.sv
// Calculator key sequencer: debounces keypad presses, accumulates decimal
// operands for the IU and emits trig/value/ClearEntry step bursts to the CU.
module calc_key_sequencer #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned DIG_MAX    = 4,
  parameter int unsigned OPW        = 14
) (
  input logic                 CLK,
  input logic                 Reset,
  calc_key_sequencer_if.slave bus
);

  localparam int unsigned CW = 4;        // debounce sample counter
  localparam int unsigned EW = 3;        // burst cycle index E0..E5
  localparam int unsigned AW = OPW + 4;  // multiply-accumulate width

  localparam logic [2:0] ST_INIT      = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_DEB_PRESS = 3'd2;
  localparam logic [2:0] ST_EMIT      = 3'd3;
  localparam logic [2:0] ST_WAIT_REL  = 3'd4;
  localparam logic [2:0] ST_DEB_REL   = 3'd5;

  localparam logic [1:0] PH_OPA  = 2'd0;
  localparam logic [1:0] PH_OPB  = 2'd1;
  localparam logic [1:0] PH_DONE = 2'd2;

  localparam logic [2:0] V_INIT  = 3'd0;
  localparam logic [2:0] V_DIGIT = 3'd1;
  localparam logic [2:0] V_ADD   = 3'd2;
  localparam logic [2:0] V_SUB   = 3'd3;
  localparam logic [2:0] V_EQ    = 3'd4;

  localparam logic [3:0] K_DIG9 = 4'd9;
  localparam logic [3:0] K_ADD  = 4'd10;
  localparam logic [3:0] K_SUB  = 4'd11;
  localparam logic [3:0] K_EQ   = 4'd12;
  localparam logic [3:0] K_CE   = 4'd13;

  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES);
  localparam logic [2:0]    DIG_LIM  = 3'(DIG_MAX);

  // State and datapath registers
  logic [2:0]     state_q,   state_d;
  logic [CW-1:0]  cnt_q,     cnt_d;
  logic [3:0]     code_q,    code_d;
  logic [EW-1:0]  ecnt_q,    ecnt_d;
  logic [1:0]     burst_q,   burst_d;
  logic           to_idle_q, to_idle_d;
  logic           trig_q,    trig_d;
  logic [2:0]     value_q,   value_d;
  logic           ce_n_q,    ce_n_d;
  logic [OPW-1:0] operand_q, operand_d;
  logic [2:0]     dcount_q,  dcount_d;
  logic [1:0]     phase_q,   phase_d;
  logic           err_q,     err_d;
  logic           busy_q,    busy_d;

  logic           accept;
  logic [EW-1:0]  last_idx;
  logic [AW-1:0]  mac;

  // Next-state, event decode and registered-output values
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    ecnt_d    = ecnt_q;
    burst_d   = burst_q;
    to_idle_d = to_idle_q;
    trig_d    = 1'b0;
    value_d   = value_q;
    ce_n_d    = 1'b1;
    operand_d = operand_q;
    dcount_d  = dcount_q;
    phase_d   = phase_q;
    err_d     = err_q;
    accept    = 1'b0;
    mac       = '0;
    last_idx  = (burst_q == 2'd0) ? EW'(0) : ({burst_q, 1'b0} - EW'(1));

    case (state_q)
      // INIT is E0 of a single value=0 pulse that releases the CU from clear
      ST_INIT: begin
        trig_d    = 1'b1;
        ecnt_d    = EW'(1);
        burst_d   = 2'd1;
        to_idle_d = 1'b1;
        state_d   = ST_EMIT;
      end

      ST_IDLE: begin
        if (bus.key_valid) begin
          code_d = bus.key_code;
          cnt_d  = CW'(1);
          if (DEB_LAST == CW'(1)) accept = 1'b1;
          else                    state_d = ST_DEB_PRESS;
        end
      end

      ST_DEB_PRESS: begin
        if (!bus.key_valid) begin
          state_d = ST_IDLE;
        end else if (bus.key_code != code_q) begin
          code_d = bus.key_code;
          cnt_d  = CW'(1);
        end else if (cnt_q + CW'(1) == DEB_LAST) begin
          accept = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // Pulses land on odd burst cycles; value stays put for the whole burst
      ST_EMIT: begin
        if (ecnt_q == last_idx) begin
          state_d = to_idle_q ? ST_IDLE : ST_WAIT_REL;
        end else begin
          ecnt_d = ecnt_q + EW'(1);
          trig_d = ~ecnt_q[0];
        end
      end

      ST_WAIT_REL: begin
        if (!bus.key_valid) begin
          cnt_d = CW'(1);
          if (DEB_LAST == CW'(1)) state_d = ST_IDLE;
          else                    state_d = ST_DEB_REL;
        end
      end

      ST_DEB_REL: begin
        if (bus.key_valid) begin
          state_d = ST_WAIT_REL;
        end else if (cnt_q + CW'(1) == DEB_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = ST_INIT;
    endcase

    // Accepted press: apply the event now so it is visible from E0
    if (accept) begin
      state_d   = ST_EMIT;
      ecnt_d    = '0;
      burst_d   = 2'd0;
      to_idle_d = 1'b0;
      mac       = AW'(operand_q) * AW'(10) + AW'(code_d);
      if (code_d <= K_DIG9) begin
        if ((phase_q != PH_DONE) && (dcount_q < DIG_LIM)) begin
          // First digit of B overwrites A, which the IU no longer needs
          if ((phase_q == PH_OPB) && (dcount_q == 3'd0)) operand_d = OPW'(code_d);
          else                                           operand_d = OPW'(mac);
          dcount_d = dcount_q + 3'd1;
          value_d  = V_DIGIT;
          burst_d  = 2'd1;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        case (code_d)
          K_ADD, K_SUB: begin
            // Operand is kept so the IU still presents A while the CU loads it
            if ((phase_q == PH_OPA) && (dcount_q != 3'd0)) begin
              value_d  = (code_d == K_ADD) ? V_ADD : V_SUB;
              burst_d  = 2'd3;
              phase_d  = PH_OPB;
              dcount_d = 3'd0;
            end else begin
              err_d = 1'b1;
            end
          end
          K_EQ: begin
            if ((phase_q == PH_OPB) && (dcount_q != 3'd0)) begin
              value_d = V_EQ;
              burst_d = 2'd2;
              phase_d = PH_DONE;
            end else begin
              err_d = 1'b1;
            end
          end
          K_CE: begin
            operand_d = '0;
            dcount_d  = 3'd0;
            ce_n_d    = 1'b0;
          end
          default: err_d = 1'b1;
        endcase
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      code_q    <= '0;
      ecnt_q    <= '0;
      burst_q   <= '0;
      to_idle_q <= 1'b0;
      trig_q    <= 1'b0;
      value_q   <= V_INIT;
      ce_n_q    <= 1'b1;
      operand_q <= '0;
      dcount_q  <= '0;
      phase_q   <= PH_OPA;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      ecnt_q    <= ecnt_d;
      burst_q   <= burst_d;
      to_idle_q <= to_idle_d;
      trig_q    <= trig_d;
      value_q   <= value_d;
      ce_n_q    <= ce_n_d;
      operand_q <= operand_d;
      dcount_q  <= dcount_d;
      phase_q   <= phase_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.trig        = trig_q;
  assign bus.value       = value_q;
  assign bus.ClearEntry  = ce_n_q;
  assign bus.operand     = operand_q;
  assign bus.digit_count = dcount_q;
  assign bus.phase       = phase_q;
  assign bus.err         = err_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Bench for calc_key_sequencer: directed test-plan steps then random key
// presses, all checked against a behavioural calculator-entry model.
module tb_calc_key_sequencer;

  localparam int DEB = 4;
  localparam int DIG = 4;
  localparam int OPW = 14;
  localparam int WIN = 30;

  logic CLK   = 1'b0;
  logic Reset = 1'b1;
  always #5 CLK = ~CLK;

  calc_key_sequencer_if #(.OPW(OPW)) bus ();

  calc_key_sequencer #(.DEB_CYCLES(DEB), .DIG_MAX(DIG), .OPW(OPW)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model of the calculator entry state
  int m_op, m_dc, m_ph, m_err, m_val;

  // Trig shape watcher: no back-to-back highs, value steady before/while high
  int         mon_viol  = 0;
  logic       prev_trig = 1'b0;
  logic [2:0] prev_val  = 3'd0;
  initial forever begin
    @(negedge CLK);
    if (bus.trig === 1'b1 && prev_trig === 1'b1) mon_viol++;
    if (bus.trig === 1'b1 && bus.value !== prev_val) mon_viol++;
    prev_trig = bus.trig;
    prev_val  = bus.value;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_op = 0; m_dc = 0; m_ph = 0; m_err = 0; m_val = 0;
  endtask

  task automatic model_key(input int code, output int n, output bit ce);
    n  = 0;
    ce = 1'b0;
    if (code <= 9) begin
      if (m_ph != 2 && m_dc < DIG) begin
        m_op  = (m_ph == 1 && m_dc == 0) ? code : m_op * 10 + code;
        m_dc  = m_dc + 1;
        m_val = 1;
        n     = 1;
      end else m_err = 1;
    end else if (code == 10 || code == 11) begin
      if (m_ph == 0 && m_dc >= 1) begin
        m_val = code - 8; n = 3; m_ph = 1; m_dc = 0;
      end else m_err = 1;
    end else if (code == 12) begin
      if (m_ph == 1 && m_dc >= 1) begin
        m_val = 4; n = 2; m_ph = 2;
      end else m_err = 1;
    end else if (code == 13) begin
      m_op = 0; m_dc = 0; ce = 1'b1;
    end else begin
      m_err = 1;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".operand"}, 32'(bus.operand), 32'(m_op));
    check({tag, ".digits"},  32'(bus.digit_count), 32'(m_dc));
    check({tag, ".phase"},   32'(bus.phase), 32'(m_ph));
    check({tag, ".err"},     32'(bus.err), 32'(m_err));
    check({tag, ".value"},   32'(bus.value), 32'(m_val));
    check({tag, ".busy"},    32'(bus.busy), 32'd0);
    check({tag, ".ce_idle"}, 32'(bus.ClearEntry), 32'd1);
  endtask

  // Hold a key for 'hold' samples, record trig and ClearEntry per cycle
  // (bit k = cycle after the k-th clock edge since the key went down).
  task automatic press(input logic [3:0] code, input int hold,
                       output logic [31:0] tmask, output logic [31:0] cmask);
    tmask = '0;
    cmask = '0;
    @(posedge CLK); #1;
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    for (int k = 0; k < WIN; k++) begin
      @(negedge CLK);
      if (bus.trig === 1'b1)       tmask[k] = 1'b1;
      if (bus.ClearEntry === 1'b0) cmask[k] = 1'b1;
      @(posedge CLK); #1;
      if (k + 1 == hold) bus.key_valid = 1'b0;
    end
  endtask

  task automatic press_chk(input logic [3:0] code, input int hold);
    logic [31:0] tm, cm, etm, ecm;
    int          n;
    bit          ce;
    string       tag;
    press(code, hold, tm, cm);
    etm = '0;
    ecm = '0;
    if (hold >= DEB) begin
      model_key(int'(code), n, ce);
      for (int i = 0; i < n; i++) etm[DEB + 1 + 2 * i] = 1'b1;
      if (ce) ecm[DEB] = 1'b1;
    end
    tag = $sformatf("key%0d_h%0d", code, hold);
    @(negedge CLK);
    check({tag, ".trig_pattern"}, tm, etm);
    check({tag, ".ce_pattern"},   cm, ecm);
    check_state(tag);
  endtask

  task automatic do_reset();
    Reset         = 1'b1;
    bus.key_valid = 1'b0;
    repeat (2) @(posedge CLK);
    #1 Reset = 1'b0;
    model_reset();
    repeat (4) @(posedge CLK);
    #1;
  endtask

  logic [31:0] tm6;

  initial begin
    int          r;
    logic [3:0]  rc;
    int          rh;

    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
    model_reset();

    // Reset values, then the INIT pulse timing after release
    @(posedge CLK);
    @(negedge CLK);
    check("rst.trig",  32'(bus.trig), 32'd0);
    check("rst.value", 32'(bus.value), 32'd0);
    check("rst.ce",    32'(bus.ClearEntry), 32'd1);
    check("rst.busy",  32'(bus.busy), 32'd0);
    check("rst.err",   32'(bus.err), 32'd0);
    @(posedge CLK);
    #1 Reset = 1'b0;
    @(negedge CLK);
    check("init.c1_trig", 32'(bus.trig), 32'd0);
    check("init.c1_ce",   32'(bus.ClearEntry), 32'd1);
    @(negedge CLK);
    check("init.c2_trig",  32'(bus.trig), 32'd1);
    check("init.c2_value", 32'(bus.value), 32'd0);
    check("init.c2_busy",  32'(bus.busy), 32'd1);
    check("init.c2_ce",    32'(bus.ClearEntry), 32'd1);
    @(negedge CLK);
    check("init.c3_trig", 32'(bus.trig), 32'd0);
    check("init.c3_busy", 32'(bus.busy), 32'd0);

    // Two digits and a too-short glitch
    press_chk(4'd1, 10);
    press_chk(4'd2, 10);
    press_chk(4'd7, 3);
    check("tp2.operand", 32'(bus.operand), 32'd12);
    check("tp2.digits",  32'(bus.digit_count), 32'd2);

    // 12 + 5 =
    press_chk(4'd10, 12);
    check("tp3.add_keeps_a", 32'(bus.operand), 32'd12);
    press_chk(4'd5, 12);
    check("tp3.b_operand", 32'(bus.operand), 32'd5);
    press_chk(4'd12, 12);
    check("tp3.done", 32'(bus.phase), 32'd2);
    press_chk(4'd3, 12);

    // Digit limit
    do_reset();
    press_chk(4'd1, 8);
    press_chk(4'd2, 8);
    press_chk(4'd3, 8);
    press_chk(4'd4, 8);
    press_chk(4'd5, 8);
    check("tp4.operand", 32'(bus.operand), 32'd1234);
    check("tp4.err",     32'(bus.err), 32'd1);

    // Ordering errors, invalid code, clear entry
    do_reset();
    press_chk(4'd10, 12);
    press_chk(4'd12, 12);
    press_chk(4'd15, 12);
    press_chk(4'd4, 10);
    press_chk(4'd5, 10);
    press_chk(4'd13, 10);
    check("tp5.operand", 32'(bus.operand), 32'd0);
    check("tp5.phase",   32'(bus.phase), 32'd0);

    // Reset landing in E2 of an add burst
    do_reset();
    press_chk(4'd1, 12);
    tm6 = '0;
    @(posedge CLK); #1;
    bus.key_valid = 1'b1;
    bus.key_code  = 4'd10;
    for (int k = 0; k < DEB + 2; k++) begin
      @(negedge CLK);
      if (bus.trig === 1'b1) tm6[k] = 1'b1;
      @(posedge CLK); #1;
    end
    Reset = 1'b1;
    @(negedge CLK);
    check("tp6.e0_e2_trig", tm6, 32'(1) << (DEB + 1));
    check("tp6.e2_value",   32'(bus.value), 32'd2);
    check("tp6.e2_trig",    32'(bus.trig), 32'd0);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("tp6.rst_trig",    32'(bus.trig), 32'd0);
    check("tp6.rst_value",   32'(bus.value), 32'd0);
    check("tp6.rst_phase",   32'(bus.phase), 32'd0);
    check("tp6.rst_operand", 32'(bus.operand), 32'd0);
    check("tp6.rst_busy",    32'(bus.busy), 32'd0);
    @(posedge CLK); #1;
    Reset         = 1'b0;
    bus.key_valid = 1'b0;
    model_reset();
    @(negedge CLK);
    check("tp6.rel_c1_trig", 32'(bus.trig), 32'd0);
    @(negedge CLK);
    check("tp6.rel_c2_trig", 32'(bus.trig), 32'd1);
    @(negedge CLK);
    check("tp6.rel_c3_trig", 32'(bus.trig), 32'd0);
    check("tp6.rel_c3_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(posedge CLK);

    // Random presses against the model
    for (int i = 0; i < 60; i++) begin
      if (i % 12 == 0) do_reset();
      r = int'($urandom_range(0, 31));
      if      (r < 16) rc = 4'(r % 10);
      else if (r < 20) rc = 4'(10 + r % 2);
      else if (r < 25) rc = 4'd12;
      else if (r < 28) rc = 4'd13;
      else             rc = 4'(14 + r % 2);
      if ($urandom_range(0, 5) == 0) rh = int'($urandom_range(1, DEB - 1));
      else                           rh = int'($urandom_range(DEB, DEB + 10));
      press_chk(rc, rh);
    end

    check("trig_shape_violations", 32'(mon_viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/calc_key_sequencer.md
Name: calc_key_sequencer

Overview:
- Front end of the calculator, placed between the keypad encoder and the calculator control unit (CU) / input unit (IU).
- Debounces raw key presses and accumulates decimal digits into a binary operand for the IU.
- Enforces operand/operator/equals ordering and drives the CU's trig/value/ClearEntry inputs.
- Emits trig pulse bursts so the CU steps through its load/clear states without extra key presses.

Parameters:
DEB_CYCLES, 4, consecutive identical samples required to accept a press or release (1..15)
DIG_MAX, 4, maximum digits per operand (1..7)
OPW, 14, operand width in bits; must hold 10^DIG_MAX - 1

Ports:
CLK  in  1  clock, all logic on rising edge
Reset  in  1  synchronous, active-high
key_valid  in  1  raw key-held level from keypad encoder
key_code  in  4  0-9 digit, 10 add, 11 sub, 12 equals, 13 clear entry, 14-15 invalid
trig  out  1  registered one-cycle step pulse to CU
value  out  3  event code to CU: 0 init, 1 digit, 2 add, 3 sub, 4 equals
ClearEntry  out  1  active-low one-cycle clear-entry pulse to CU
operand  out  OPW  binary value of the digits entered, to IU
digit_count  out  3  digits in current operand
phase  out  2  0 OPA, 1 OPB, 2 DONE
err  out  1  sticky illegal/overflow flag
busy  out  1  high whenever key FSM is not IDLE

Behaviour:
- Reset (sampled high at posedge): trig=0, value=0, ClearEntry=1, operand=0, digit_count=0, phase=0, err=0, busy=0.
  - Key FSM goes to INIT. Reset has priority over every other event.
  - Reset mid-burst or mid-debounce aborts: no further pulses from that event.
- INIT: after Reset drops, one burst of 1 pulse with value=0 (moves CU out of its clear state), then IDLE.
- Key FSM states: INIT, IDLE, DEB_PRESS, EMIT, WAIT_REL, DEB_REL.
  - IDLE: key_valid=1 -> DEB_PRESS, count=1, code latched.
  - DEB_PRESS: key_valid=0 -> IDLE.
  - DEB_PRESS: key_code differs from latched code -> restart with count=1 on the new code.
  - DEB_PRESS: count reaches DEB_CYCLES -> EMIT. A 1-cycle-to-(DEB_CYCLES-1)-cycle press produces nothing.
  - EMIT: E0 is the cycle after acceptance. All register updates (operand, digit_count, phase, value, err) take effect at the E0 edge.
  - EMIT burst: trig=1 in E1, E3, E5... for N pulses, low between pulses; value held from E0 until the next event.
  - EMIT end: after the last pulse (or E0 if N=0) -> WAIT_REL.
  - WAIT_REL: key_valid=0 -> DEB_REL. key_valid is ignored during EMIT.
  - DEB_REL: key_valid=1 -> back to WAIT_REL; DEB_CYCLES consecutive low samples -> IDLE.
  - One event per physical press, regardless of hold time.
- Event actions:
  - Digit d, phase!=DONE, digit_count<DIG_MAX: operand <= operand*10+d; digit_count++; N=1, value=1.
  - If digit_count=0 and phase=OPB, the digit replaces the operand: operand <= d.
  - Digit in DONE or with digit_count=DIG_MAX: err<=1, N=0, operand unchanged.
  - Add/sub, phase=OPA, digit_count>=1: value=2/3, N=3, phase<=OPB, digit_count<=0.
    - operand is retained so the IU still holds A while the CU loads it.
  - Add/sub in any other case: err<=1, N=0.
  - Equals, phase=OPB, digit_count>=1: value=4, N=2, phase<=DONE, operand retained.
  - Equals otherwise: err<=1, N=0.
  - Clear entry, any phase: operand<=0, digit_count<=0, ClearEntry=0 in E0 only, N=0; phase and value unchanged.
  - Codes 14/15: err<=1, N=0.
- err is cleared only by Reset. No state other than err changes on a rejected event.
- Arithmetic: operand*10+d is computed in OPW+4 bits; the DIG_MAX limit guarantees no truncation.
- The CU uses trig as its clock. value changes at least one cycle before any trig rising edge and is never changed while trig=1.

Test Plan:
1. Reset 2 cycles then release -> value=0, trig high exactly in the 2nd cycle after release, busy falls 1 cycle later; ClearEntry=1 throughout.
2. key 1 held 10 cycles, release; key 2 same; 3-cycle glitch of key 7 -> two single trig pulses with value=1, operand=12, digit_count=2; glitch produces no pulse and no change.
3. 1,2,add,5,equals -> add gives 3 pulses at E1/E3/E5 with value=2, phase=1, operand stays 12 until '5' sets operand=5; equals gives 2 pulses with value=4, phase=2.
4. DIG_MAX=4, keys 1,2,3,4,5 -> fifth has no trig, err=1, operand=1234, digit_count=4.
5. Add with no digits, equals in OPA, code 15 -> no trig, err=1; then CE -> ClearEntry=0 for one cycle, operand=0, phase unchanged.
6. Reset asserted at E2 of an add burst -> outputs at reset values next cycle, no E3/E5 pulses, INIT pulse reissued after release.
